// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// FSM codes, default widths and the counter-width helper.
package divider_pkg;

  localparam int DEF_DIVIDEND_W = 6;
  localparam int DEF_DIVISOR_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle of the divider.
// Macro DIV_SIGNED_EN adds the in_signed operand flag.
interface seq_divider_if
  import divider_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] in_dividend;
  logic [DIVISOR_W-1:0]  in_divisor;
`ifdef DIV_SIGNED_EN
  logic                  in_signed;
`endif
  logic                  out_valid;
  logic                  out_ready;
  logic [DIVIDEND_W-1:0] out_quotient;
  logic [DIVISOR_W-1:0]  out_remainder;
  logic                  out_dbz;

`ifdef DIV_SIGNED_EN
  modport master (
    output in_valid, in_dividend, in_divisor,
    output in_signed, out_ready,
    input  in_ready, out_valid, out_quotient,
    input  out_remainder, out_dbz
  );

  modport slave (
    input  in_valid, in_dividend, in_divisor,
    input  in_signed, out_ready,
    output in_ready, out_valid, out_quotient,
    output out_remainder, out_dbz
  );
`else
  modport master (
    output in_valid, in_dividend, in_divisor,
    output out_ready,
    input  in_ready, out_valid, out_quotient,
    input  out_remainder, out_dbz
  );

  modport slave (
    input  in_valid, in_dividend, in_divisor,
    input  out_ready,
    output in_ready, out_valid, out_quotient,
    output out_remainder, out_dbz
  );
`endif

endinterface

// File: rtl/seq_divider_step.sv
// One restoring division iteration (shift in a bit, trial subtract).
// Combinational; also reused by the array divider.
module divider_step #(
  parameter int DIVISOR_W = 3
) (
  input  logic [DIVISOR_W-1:0] rem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] rem_out,
  output logic                 q_bit
);

  logic [DIVISOR_W:0] shifted;
  logic [DIVISOR_W:0] dext;

  assign shifted = {rem_in, bit_in};
  assign dext    = {1'b0, divisor};
  assign q_bit   = shifted >= dext;

  // rem_in < divisor keeps either result inside DIVISOR_W bits
  assign rem_out = DIVISOR_W'(q_bit ? shifted - dext : shifted);

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per clock.
// Macro DIV_SIGNED_EN enables two's-complement mode via in_signed.
module seq_divider
  import divider_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input logic         clk,
  input logic         rst,
  seq_divider_if.slave bus
);

  localparam int QW    = DIVIDEND_W;
  localparam int RW    = DIVISOR_W;
  localparam int CNT_W = clog2(QW);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [QW-1:0]    dvd;
  logic [RW-1:0]    dvs;
  logic [RW-1:0]    rem;
  logic [QW-2:0]    quo;
  logic             neg_q;
  logic             neg_r;

  logic [QW-1:0]    q_out;
  logic [RW-1:0]    r_out;
  logic             dbz_out;

  logic             idle;
  logic             zero_div;
  logic             a_neg;
  logic             b_neg;
  logic [QW-1:0]    a_mag;
  logic [RW-1:0]    b_mag;

  logic [RW-1:0]    s_rem;
  logic             s_bit;
  logic [RW-1:0]    s_dvs;
  logic [RW-1:0]    s_rout;
  logic             s_q;
  logic [QW-1:0]    q_full;
  logic [QW-1:0]    q_fix;
  logic [RW-1:0]    r_fix;

  assign idle     = state == IDLE;
  assign zero_div = bus.in_divisor == '0;

`ifdef DIV_SIGNED_EN
  assign a_neg = bus.in_signed & bus.in_dividend[QW-1];
  assign b_neg = bus.in_signed & bus.in_divisor[RW-1];
`else
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
`endif

  assign a_mag = a_neg ? -bus.in_dividend : bus.in_dividend;
  assign b_mag = b_neg ? -bus.in_divisor  : bus.in_divisor;

  // The accepting edge already retires the dividend MSB
  assign s_rem = idle ? '0 : rem;
  assign s_bit = idle ? a_mag[QW-1] : dvd[cnt];
  assign s_dvs = idle ? b_mag : dvs;

  divider_step #(
    .DIVISOR_W(RW)
  ) u_step (
    .rem_in (s_rem),
    .bit_in (s_bit),
    .divisor(s_dvs),
    .rem_out(s_rout),
    .q_bit  (s_q)
  );

  assign q_full = {(idle ? {(QW-1){1'b0}} : quo), s_q};
  assign q_fix  = neg_q ? -q_full : q_full;
  assign r_fix  = neg_r ? -s_rout : s_rout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      dvd     <= '0;
      dvs     <= '0;
      rem     <= '0;
      quo     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      q_out   <= '0;
      r_out   <= '0;
      dbz_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (zero_div) begin
              state   <= DONE;
              q_out   <= '1;
              r_out   <= bus.in_dividend[RW-1:0];
              dbz_out <= 1'b1;
            end else begin
              state <= BUSY;
              dvd   <= a_mag;
              dvs   <= b_mag;
              rem   <= s_rout;
              quo   <= q_full[QW-2:0];
              cnt   <= CNT_W'(QW-2);
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
            end
          end
        end
        BUSY: begin
          rem <= s_rout;
          quo <= q_full[QW-2:0];
          if (cnt == '0) begin
            state   <= DONE;
            q_out   <= q_fix;
            r_out   <= r_fix;
            dbz_out <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready      = idle;
  assign bus.out_valid     = state == DONE;
  assign bus.out_quotient  = q_out;
  assign bus.out_remainder = r_out;
  assign bus.out_dbz       = dbz_out;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (6/3 widths).
// Signed vectors run when DIV_SIGNED_EN is defined.
module tb_seq_divider;
  import divider_pkg::*;

  typedef struct packed {
    logic [5:0] q;
    logic [2:0] r;
    logic       d;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_divider_if #(.DIVIDEND_W(6), .DIVISOR_W(3)) bus();

  seq_divider #(
    .DIVIDEND_W(6),
    .DIVISOR_W (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   total  = 0;
  int   passed = 0;
  res_t exp_q[$];
  res_t cmp_e;
  res_t mon_e;
  logic mon_s;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Plain arithmetic reference; SV integer division truncates toward zero
  function automatic res_t model(input logic [5:0] a,
                                 input logic [2:0] b,
                                 input logic s);
    res_t o;
    int ai, bi, qi, ri;
    if (b == 3'd0) begin
      o.q = 6'h3f;
      o.r = a[2:0];
      o.d = 1'b1;
    end else begin
      ai = s ? int'($signed(a)) : int'(a);
      bi = s ? int'($signed(b)) : int'(b);
      qi = ai / bi;
      ri = ai % bi;
      o.q = qi[5:0];
      o.r = ri[2:0];
      o.d = 1'b0;
    end
    return o;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else if (bus.in_valid && bus.in_ready) begin
      mon_s = 1'b0;
`ifdef DIV_SIGNED_EN
      mon_s = bus.in_signed;
`endif
      mon_e = model(bus.in_dividend, bus.in_divisor, mon_s);
      exp_q.push_back(mon_e);
    end else if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(bus.out_valid), 0);
      end else begin
        cmp_e = exp_q[0];
        check("cmp_q", 32'(bus.out_quotient), 32'(cmp_e.q));
        check("cmp_r", 32'(bus.out_remainder), 32'(cmp_e.r));
        check("cmp_dbz", 32'(bus.out_dbz), 32'(cmp_e.d));
      end
    end
  end

  task automatic do_op(input logic [5:0] a,
                       input logic [2:0] b,
                       input int hold,
                       output int lat,
                       output logic [5:0] q,
                       output logic [2:0] r,
                       output logic d);
    int n;
    @(negedge clk);
    bus.in_dividend = a;
    bus.in_divisor  = b;
    bus.in_valid    = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 40);
    check("valid_seen", 32'(bus.out_valid), 1);
    q = bus.out_quotient;
    r = bus.out_remainder;
    d = bus.out_dbz;
    for (int i = 0; i < hold; i++) begin
      check("bp_in_ready", 32'(bus.in_ready), 0);
      check("bp_valid", 32'(bus.out_valid), 1);
      check("bp_q_stable", 32'(bus.out_quotient), 32'(q));
      check("bp_r_stable", 32'(bus.out_remainder), 32'(r));
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("post_valid", 32'(bus.out_valid), 0);
    check("post_in_ready", 32'(bus.in_ready), 1);
    check("post_q_hold", 32'(bus.out_quotient), 32'(q));
  endtask

  int         lat;
  logic [5:0] q;
  logic [2:0] r;
  logic       d;
  logic [5:0] va [7] = '{13, 0, 7, 63, 1, 62, 36};
  logic [2:0] vb [7] = '{5, 3, 7, 1, 7, 4, 0};

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_dividend = '0;
    bus.in_divisor  = '0;
    bus.out_ready   = 1'b0;
`ifdef DIV_SIGNED_EN
    bus.in_signed   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_q", 32'(bus.out_quotient), 0);
    check("rst_r", 32'(bus.out_remainder), 0);
    check("rst_dbz", 32'(bus.out_dbz), 0);
    rst = 1'b0;

    do_op(6'd45, 3'd6, 0, lat, q, r, d);
    check("lat_45_6", 32'(lat), 6);
    check("q_45_6", 32'(q), 7);
    check("r_45_6", 32'(r), 3);
    check("dbz_45_6", 32'(d), 0);

    do_op(6'd63, 3'd7, 0, lat, q, r, d);
    check("q_63_7", 32'(q), 9);
    check("r_63_7", 32'(r), 0);

    do_op(6'd5, 3'd0, 0, lat, q, r, d);
    check("lat_5_0", 32'(lat), 1);
    check("q_5_0", 32'(q), 63);
    check("r_5_0", 32'(r), 5);
    check("dbz_5_0", 32'(d), 1);

    do_op(6'd45, 3'd6, 5, lat, q, r, d);
    check("bp_q_45_6", 32'(q), 7);

    for (int i = 0; i < 7; i++) begin
      do_op(va[i], vb[i], i % 2, lat, q, r, d);
      check("tbl_lat", 32'(lat), (vb[i] == 3'd0) ? 1 : 6);
    end

    @(negedge clk);
    bus.in_dividend = 6'd45;
    bus.in_divisor  = 3'd6;
    bus.in_valid    = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_valid", 32'(bus.out_valid), 0);
    check("mid_busy_ready", 32'(bus.in_ready), 0);
    rst = 1'b1;
    #1;
    check("arst_in_ready", 32'(bus.in_ready), 1);
    check("arst_valid", 32'(bus.out_valid), 0);
    check("arst_q", 32'(bus.out_quotient), 0);
    check("arst_r", 32'(bus.out_remainder), 0);
    check("arst_dbz", 32'(bus.out_dbz), 0);
    @(negedge clk);
    rst = 1'b0;
    do_op(6'd12, 3'd4, 0, lat, q, r, d);
    check("lat_12_4", 32'(lat), 6);
    check("q_12_4", 32'(q), 3);
    check("r_12_4", 32'(r), 0);

`ifdef DIV_SIGNED_EN
    bus.in_signed = 1'b1;
    do_op(6'b101100, 3'd3, 0, lat, q, r, d);
    check("s_lat", 32'(lat), 6);
    check("s_q_m20_3", 32'(q), 32'(6'b111010));
    check("s_r_m20_3", 32'(r), 32'(3'b110));
    do_op(6'b100000, 3'b111, 0, lat, q, r, d);
    check("s_q_m32_m1", 32'(q), 32'(6'b100000));
    check("s_r_m32_m1", 32'(r), 0);
    check("s_dbz_m32_m1", 32'(d), 0);
    do_op(6'b111001, 3'b010, 0, lat, q, r, d);
    check("s_q_m7_2", 32'(q), 32'(6'b111101));
    check("s_r_m7_2", 32'(r), 32'(3'b111));
    do_op(6'd17, 3'b100, 0, lat, q, r, d);
    check("s_q_17_m4", 32'(q), 32'(6'b111100));
    check("s_r_17_m4", 32'(r), 1);
    do_op(6'b111111, 3'b000, 0, lat, q, r, d);
    check("s_q_dbz", 32'(q), 63);
    check("s_r_dbz", 32'(r), 32'(3'b111));
    check("s_dbz", 32'(d), 1);
    bus.in_signed = 1'b0;
`endif

    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
